// File: rtl/gcn_operand_server_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gcn_operand_server_if : host load stream and GCN row-read bus             |
// | Optional GCN_OPSRV_RDCOUNT_EN adds rd_count.   Revision: 1.0              |
// +--------------------------------------------------------------------------+
interface gcn_operand_server_if #(
    parameter int DATA_WIDTH    = 5,
    parameter int ADDRESS_WIDTH = 13,
    parameter int FEATURE_COLS  = 96
);
    logic                               load_start;
    logic                               load_valid;
    logic [DATA_WIDTH-1:0]              load_data;
    logic                               load_ready;
    logic                               mem_ready;
    logic                               enable_read;
    logic [ADDRESS_WIDTH-1:0]           read_address;
    logic [FEATURE_COLS*DATA_WIDTH-1:0] data_out;
    logic                               data_valid;
    logic                               addr_error;
`ifdef GCN_OPSRV_RDCOUNT_EN
    logic [15:0]                        rd_count;

    modport master (
        output load_start, load_valid, load_data, enable_read, read_address,
        input  load_ready, mem_ready, data_out, data_valid, addr_error, rd_count
    );
    modport slave (
        input  load_start, load_valid, load_data, enable_read, read_address,
        output load_ready, mem_ready, data_out, data_valid, addr_error, rd_count
    );
`else
    modport master (
        output load_start, load_valid, load_data, enable_read, read_address,
        input  load_ready, mem_ready, data_out, data_valid, addr_error
    );
    modport slave (
        input  load_start, load_valid, load_data, enable_read, read_address,
        output load_ready, mem_ready, data_out, data_valid, addr_error
    );
`endif
endinterface
`default_nettype wire

// File: rtl/gcn_operand_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gcn_operand_server : loadable weight/feature store serving full-row reads |
// | Optional GCN_OPSRV_RDCOUNT_EN adds a saturating read counter. Rev: 1.0    |
// +--------------------------------------------------------------------------+
module gcn_operand_server #(
    parameter int FEATURE_COLS  = 96,
    parameter int FEATURE_ROWS  = 6,
    parameter int WEIGHT_COLS   = 3,
    parameter int DATA_WIDTH    = 5,
    parameter int ADDRESS_WIDTH = 13,
    parameter int FEATURE_BASE  = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    gcn_operand_server_if.slave  bus
);
    localparam int CW  = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1;
    localparam int WRW = (WEIGHT_COLS  > 1) ? $clog2(WEIGHT_COLS)  : 1;
    localparam int FRW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int RW  = (WRW > FRW) ? WRW : FRW;
    localparam int ROW_BITS = FEATURE_COLS * DATA_WIDTH;

    localparam logic [CW-1:0] COL_LAST  = CW'(FEATURE_COLS - 1);
    localparam logic [RW-1:0] WROW_LAST = RW'(WEIGHT_COLS - 1);
    localparam logic [RW-1:0] FROW_LAST = RW'(FEATURE_ROWS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] W_LIMIT = ADDRESS_WIDTH'(WEIGHT_COLS);
    localparam logic [ADDRESS_WIDTH-1:0] F_BASE  = ADDRESS_WIDTH'(FEATURE_BASE);
    localparam logic [ADDRESS_WIDTH-1:0] F_LIMIT = ADDRESS_WIDTH'(FEATURE_BASE + FEATURE_ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            bank;       // 0: weight bank, 1: feature bank

    logic [ROW_BITS-1:0] wmem [WEIGHT_COLS];
    logic [ROW_BITS-1:0] fmem [FEATURE_ROWS];

    logic            accept;
    logic            rd_hit;
    logic            in_w;
    logic            in_f;
    logic [WRW-1:0]  widx;
    logic [FRW-1:0]  fidx;

    // load_start in the same cycle discards the offered element
    assign accept = bus.load_ready & bus.load_valid & ~bus.load_start;
    assign rd_hit = (state == READY) & bus.enable_read;
    assign in_w   = bus.read_address < W_LIMIT;
    assign in_f   = (bus.read_address >= F_BASE) && (bus.read_address < F_LIMIT);
    assign widx   = WRW'(bus.read_address);
    assign fidx   = FRW'(bus.read_address - F_BASE);

    // Storage keeps its contents through reset
    always_ff @(posedge clk) begin
        if (accept) begin
            if (!bank)
                wmem[WRW'(row)][col*DATA_WIDTH +: DATA_WIDTH] <= bus.load_data;
            else
                fmem[FRW'(row)][col*DATA_WIDTH +: DATA_WIDTH] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            bank           <= 1'b0;
            bus.load_ready <= 1'b0;
            bus.mem_ready  <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.addr_error <= 1'b0;
`ifdef GCN_OPSRV_RDCOUNT_EN
            bus.rd_count   <= 16'd0;
`endif
        end else begin
            bus.data_valid <= rd_hit;
            if (rd_hit) begin
                if (in_w)
                    bus.data_out <= wmem[widx];
                else if (in_f)
                    bus.data_out <= fmem[fidx];
                else
                    bus.data_out <= '0;
            end

            if (rd_hit && !in_w && !in_f)
                bus.addr_error <= 1'b1;
            else if (bus.load_start)
                bus.addr_error <= 1'b0;

`ifdef GCN_OPSRV_RDCOUNT_EN
            if (bus.load_start)
                bus.rd_count <= rd_hit ? 16'd1 : 16'd0;
            else if (rd_hit && (bus.rd_count != 16'hFFFF))
                bus.rd_count <= bus.rd_count + 16'd1;
`endif

            case (state)
                IDLE: begin
                    if (bus.load_start) begin
                        state          <= LOAD;
                        bus.load_ready <= 1'b1;
                        col            <= '0;
                        row            <= '0;
                        bank           <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.load_start) begin
                        col  <= '0;
                        row  <= '0;
                        bank <= 1'b0;
                    end else if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (!bank && (row == WROW_LAST)) begin
                                row  <= '0;
                                bank <= 1'b1;
                            end else if (bank && (row == FROW_LAST)) begin
                                row            <= '0;
                                bank           <= 1'b0;
                                state          <= READY;
                                bus.load_ready <= 1'b0;
                                bus.mem_ready  <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (bus.load_start) begin
                        state          <= LOAD;
                        bus.mem_ready  <= 1'b0;
                        bus.load_ready <= 1'b1;
                        col            <= '0;
                        row            <= '0;
                        bank           <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.load_ready <= 1'b0;
                    bus.mem_ready  <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gcn_operand_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gcn_operand_server : randomized scoreboard bench for the row server    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_gcn_operand_server;
    localparam int FC = 96, FR = 6, WC = 3, DW = 5, AW = 13, FB = 512;
    localparam int TOTAL = (WC + FR) * FC;
    localparam int ROW_BITS = FC * DW;

    typedef struct {
        logic [ROW_BITS-1:0] data;
        logic                err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    gcn_operand_server_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FEATURE_COLS(FC)) bus ();

    gcn_operand_server #(
        .FEATURE_COLS(FC), .FEATURE_ROWS(FR), .WEIGHT_COLS(WC),
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FEATURE_BASE(FB)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    // Reference model: flat element image in load order plus sticky/ready flags
    logic [DW-1:0] img [TOTAL];
    bit   model_ready;
    bit   exp_err;
    int   exp_cnt;
    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [ROW_BITS-1:0] ref_row(input int a, output bit oor);
        logic [ROW_BITS-1:0] r;
        int base;
        r = '0;
        oor = 1'b0;
        base = 0;
        if (a < WC) base = a * FC;
        else if (a >= FB && a < FB + FR) base = (WC + a - FB) * FC;
        else oor = 1'b1;
        if (!oor)
            for (int c = 0; c < FC; c++) r[c*DW +: DW] = img[base + c];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic rd(input int a);
        bit oor;
        logic [ROW_BITS-1:0] d;
        exp_t e;
        bus.enable_read  = 1'b1;
        bus.read_address = a[AW-1:0];
        if (model_ready) begin
            d = ref_row(a, oor);
            if (oor) exp_err = 1'b1;
            if (exp_cnt < 65535) exp_cnt++;
            e.data = d;
            e.err  = exp_err;
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        bus.enable_read = 1'b0;
    endtask

    function automatic int pick_addr();
        int r;
        r = int'($urandom_range(0, 11));
        if (r < 3) return r;
        if (r < 9) return FB + r - 3;
        case (r)
            9:  return WC;
            10: return FB + FR;
            default: return int'($urandom_range(FB + FR, (1 << AW) - 1));
        endcase
    endfunction

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) begin
            rd(pick_addr());
            step();
            if ($urandom_range(0, 3) == 0) step();
        end
    endtask

    task automatic do_load(input bit rnd, input int restart_at, input bit rd_with_start);
        int idx, cyc;
        bit restarted;
        bus.load_start = 1'b1;
        bus.load_valid = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;
        if (rd_with_start) rd(1);
        model_ready = 1'b0;
        @(posedge clk); #1;
        bus.load_start  = 1'b0;
        bus.enable_read = 1'b0;
        @(negedge clk);
        chk("load_ready_in_load", 32'(bus.load_ready), 32'd1);
        chk("mem_ready_drop", 32'(bus.mem_ready), 32'd0);
        chk("addr_error_clear", 32'(bus.addr_error), 32'd0);
        @(posedge clk); #1;
        idx = 0; cyc = 0; restarted = 1'b0;
        while (idx < TOTAL) begin
            bus.enable_read  = 1'($urandom_range(0, 1));
            bus.read_address = AW'($urandom);
            if (!restarted && restart_at >= 0 && idx == restart_at) begin
                bus.load_start = 1'b1;
                bus.load_valid = 1'b1;
                bus.load_data  = DW'($urandom);
                restarted = 1'b1;
                idx = 0;
            end else begin
                bus.load_start = 1'b0;
                bus.load_valid = rnd ? ($urandom_range(0, 3) != 0) : (cyc % 3 != 2);
                if (bus.load_valid) begin
                    img[idx] = rnd ? DW'($urandom) : DW'(idx % 32);
                    bus.load_data = img[idx];
                    idx++;
                end
            end
            cyc++;
            @(negedge clk);
            if (idx == TOTAL || idx == TOTAL / 2 || (restarted && idx == 0))
                chk("mem_ready_low_during_load", 32'(bus.mem_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.load_start  = 1'b0;
        bus.load_valid  = 1'b0;
        bus.enable_read = 1'b0;
        @(negedge clk);
        chk("mem_ready_rise", 32'(bus.mem_ready), 32'd1);
        chk("load_ready_after_load", 32'(bus.load_ready), 32'd0);
        model_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    // Monitor: every data_valid strobe must match the oldest outstanding read
    always @(negedge clk) begin
        if (reset_n && bus.data_valid) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: data_valid=1 with no read outstanding, expected 0");
            end else begin
                mon_e = q.pop_front();
                if (bus.data_out !== mon_e.data || bus.addr_error !== mon_e.err) begin
                    miscompares++;
                    $display("FAIL read_result: got err=%0b data=%h, expected err=%0b data=%h",
                             bus.addr_error, bus.data_out, mon_e.err, mon_e.data);
                end
            end
        end
    end

    initial begin
        reset_n          = 1'b0;
        bus.load_start   = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_data    = '0;
        bus.enable_read  = 1'b0;
        bus.read_address = '0;
        model_ready = 1'b0; exp_err = 1'b0; exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(bus.data_out == '0), 32'd1);
        chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
        chk("rst_addr_error", 32'(bus.addr_error), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reads in IDLE are ignored
        rd(1); step(); rd(FB); step();
        @(negedge clk);
        chk("idle_read_valid", 32'(bus.data_valid), 32'd0);
        chk("idle_read_hold", 32'(bus.data_out == '0), 32'd1);
        @(posedge clk); #1;

        do_load(1'b0, -1, 1'b0);

        rd(1); step();
        rd(FB); step(); rd(FB + 5); step(); rd(2); step();
        step();
        rd(WC); step(); rd(FB + FR); step();
        repeat (3) step();
        @(negedge clk);
        chk("addr_error_sticky", 32'(bus.addr_error), 32'(exp_err));
        chk("data_out_zero_after_oor", 32'(bus.data_out == '0), 32'd1);
`ifdef GCN_OPSRV_RDCOUNT_EN
        chk("rd_count_a", 32'(bus.rd_count), 32'(exp_cnt));
`endif
        @(posedge clk); #1;
        reads(40);
        repeat (2) step();

        // Restart a load, then reset asynchronously after 100 elements
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        q.delete();
        for (int i = 0; i < 100; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = DW'(i);
            step();
        end
        bus.load_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_data_out", 32'(bus.data_out == '0), 32'd1);
        chk("mid_rst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("mid_rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("mid_rst_load_ready", 32'(bus.load_ready), 32'd0);
        chk("mid_rst_addr_error", 32'(bus.addr_error), 32'd0);
        model_ready = 1'b0; exp_err = 1'b0; exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = DW'($urandom);
            if (i >= 3) rd(FB + 1);
            step();
            @(negedge clk);
            chk("idle_ignores_load_ready", 32'(bus.load_ready), 32'd0);
            chk("idle_ignores_mem_ready", 32'(bus.mem_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b0;

        do_load(1'b1, -1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rd(pick_addr() % WC);
            step();
        end
        repeat (2) step();
`ifdef GCN_OPSRV_RDCOUNT_EN
        @(negedge clk);
        chk("rd_count_five", 32'(bus.rd_count), 32'd5);
        @(posedge clk); #1;
`endif
        reads(20);

        do_load(1'b1, 400, 1'b1);
        reads(40);
        repeat (3) step();
        @(negedge clk);
        chk("addr_error_final", 32'(bus.addr_error), 32'(exp_err));
`ifdef GCN_OPSRV_RDCOUNT_EN
        chk("rd_count_final", 32'(bus.rd_count), 32'(exp_cnt));
`endif
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
